// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
//   state_e : detector FSM state, 2-bit encoding
//   fill_w  : width of the fill counter needed to count 0..PAT_W
package seq_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

  // The fill counter must hold PAT_W itself, hence +1.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with a sticky saturation flag.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   inc_i     : count one match
//   clr_i     : synchronous clear of count and flag (beats inc_i)
//   cnt_o     : current count, holds at all-ones
//   sat_o     : set once the count reaches all-ones, cleared only by rst/clr_i
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (inc_i && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
      // Flag rises on the same edge the count lands on all-ones.
      sat_d = sat_q | (&cnt_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector. One bit is sampled per clock with
// I_valid high; when the last PAT_W valid bits equal the active pattern (MSB =
// oldest bit) F pulses for one cycle and the saturating match counter steps.
// mode_ovl=1 keeps history after a hit (overlapping), mode_ovl=0 restarts.
// Ports:
//   clock, R   : clock, asynchronous active-high reset
//   I, I_valid : serial data bit and its qualifier
//   mode_ovl   : 1 = overlapping, 0 = non-overlapping detection
//   clr        : synchronous clear of history, count and saturation flag
//   F          : registered match pulse
//   match_cnt  : saturating number of matches since reset/clr
//   cnt_sat    : sticky, match_cnt has reached all-ones
// Build option SEQDET_PROG_EN adds pat_load/pat_in: a run-time loadable
// pattern register (reset value PATTERN); loading restarts the history but
// keeps the count. Without it the pattern is the constant PATTERN.
module seq_detector_param
  import seq_detector_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  parameter int               CNT_W   = 8
) (
  input  logic             clock,
  input  logic             R,
  input  logic             I,
  input  logic             I_valid,
  input  logic             mode_ovl,
  input  logic             clr,
`ifdef SEQDET_PROG_EN
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
`endif
  output logic             F,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int             FW        = fill_w(PAT_W);
  localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_W);

  state_e           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d, fill_nxt;
  logic [PAT_W-1:0] sreg_q, sreg_d, sreg_shift;
  logic [PAT_W-1:0] pat_act;
  logic             f_q, hit, restart;

`ifdef SEQDET_PROG_EN
  logic [PAT_W-1:0] pat_q;

  always_ff @(posedge clock or posedge R) begin
    if (R)                   pat_q <= PATTERN;
    else if (pat_load && !clr) pat_q <= pat_in;
  end

  assign pat_act = pat_q;
  assign restart = clr | pat_load;
`else
  assign pat_act = PATTERN;
  assign restart = clr;
`endif

  assign sreg_shift = {sreg_q[PAT_W-2:0], I};

  // Fill count as it would be after accepting the current bit.
  always_comb begin
    fill_nxt = FW'(1);
    case (state_q)
      ST_FILL:  fill_nxt = fill_q + FW'(1);
      ST_ARMED: fill_nxt = fill_q;
      default:  fill_nxt = FW'(1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    sreg_d  = sreg_q;
    hit     = 1'b0;
    if (restart) begin
      // Same-cycle valid bit is deliberately dropped.
      state_d = ST_IDLE;
      fill_d  = '0;
      sreg_d  = '0;
    end else if (I_valid) begin
      sreg_d  = sreg_shift;
      fill_d  = fill_nxt;
      state_d = (fill_nxt == FILL_FULL) ? ST_ARMED : ST_FILL;
      hit     = (fill_nxt == FILL_FULL) && (sreg_shift == pat_act);
      if (hit && !mode_ovl) begin
        state_d = ST_IDLE;
        fill_d  = '0;
        sreg_d  = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge R) begin
    if (R) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      sreg_q  <= '0;
      f_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      sreg_q  <= sreg_d;
      f_q     <= hit;
    end
  end

  seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clock),
    .rst   (R),
    .inc_i (hit),
    .clr_i (clr),
    .cnt_o (match_cnt),
    .sat_o (cnt_sat)
  );

  assign F = f_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: a default instance (CNT_W=8) and a CNT_W=2
// instance share one stimulus stream so saturation is seen on the small one.
module tb_seq_detector_param;
  import seq_detector_pkg::*;

  logic       clock = 1'b0;
  logic       R = 1'b0;
  logic       I = 1'b0, I_valid = 1'b0, mode_ovl = 1'b0, clr = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       F, F2, cnt_sat, cnt_sat2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  always #5 clock = ~clock;

  seq_detector_param dut (
    .clock(clock), .R(R), .I(I), .I_valid(I_valid), .mode_ovl(mode_ovl), .clr(clr),
`ifdef SEQDET_PROG_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .F(F), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clock(clock), .R(R), .I(I), .I_valid(I_valid), .mode_ovl(mode_ovl), .clr(clr),
`ifdef SEQDET_PROG_EN
    .pat_load(pat_load), .pat_in(pat_in),
`endif
    .F(F2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  typedef struct {
    logic  i, v, ovl, c;
    logic  ef;
    int    ecnt;
    logic  idle;
    string name;
  } vec_t;

  typedef struct {
    logic  ef;
    int    ecnt;
    logic  idle;
    string name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(input logic i, v, ovl, c, ef, input int ecnt,
                              input logic idle, input string name);
    vec_t r;
    r.i = i; r.v = v; r.ovl = ovl; r.c = c; r.ef = ef; r.ecnt = ecnt;
    r.idle = idle; r.name = name;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Small instance sees the same hits, clipped at 3.
  task automatic check_all(input string name, input logic ef, input int ecnt);
    check({name, ".F"},    int'(F),         int'(ef));
    check({name, ".cnt"},  int'(match_cnt), ecnt);
    check({name, ".sat"},  int'(cnt_sat),   int'(ecnt >= 255));
    check({name, ".F2"},   int'(F2),        int'(ef));
    check({name, ".cnt2"}, int'(match_cnt2), (ecnt > 3) ? 3 : ecnt);
    check({name, ".sat2"}, int'(cnt_sat2),  int'(ecnt >= 3));
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clock);
    I = v.i; I_valid = v.v; mode_ovl = v.ovl; clr = v.c;
    e.ef = v.ef; e.ecnt = v.ecnt; e.idle = v.idle; e.name = v.name;
    sb.push_back(e);
    @(posedge clock); #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check_all(e.name, e.ef, e.ecnt);
      if (e.idle) check({e.name, ".state"}, int'(dut.state_q), int'(ST_IDLE));
    end
  endtask

  task automatic bit_in(input logic i, v, ovl, ef, input int ecnt, input string name);
    vec_t r;
    r.i = i; r.v = v; r.ovl = ovl; r.c = 1'b0; r.ef = ef; r.ecnt = ecnt;
    r.idle = 1'b0; r.name = name;
    step(r);
  endtask

  initial begin
    // overlapping, 1001001 -> hits on bits 4 and 7
    add(1,1,1,0, 0,0,0,"ovl_b1"); add(0,1,1,0, 0,0,0,"ovl_b2");
    add(0,1,1,0, 0,0,0,"ovl_b3"); add(1,1,1,0, 1,1,0,"ovl_b4");
    add(0,1,1,0, 0,1,0,"ovl_b5"); add(0,1,1,0, 0,1,0,"ovl_b6");
    add(1,1,1,0, 1,2,0,"ovl_b7");
    add(1,1,1,1, 0,0,1,"clr_with_valid");
    // non-overlapping, same stream -> one hit, back to idle
    add(1,1,0,0, 0,0,0,"nov_b1"); add(0,1,0,0, 0,0,0,"nov_b2");
    add(0,1,0,0, 0,0,0,"nov_b3"); add(1,1,0,0, 1,1,1,"nov_b4");
    add(0,1,0,0, 0,1,0,"nov_b5"); add(0,1,0,0, 0,1,0,"nov_b6");
    add(1,1,0,0, 0,1,0,"nov_b7");
    add(0,0,0,1, 0,0,1,"clr2");
    // four overlapping hits: small counter saturates on the third
    for (int k = 0; k < 4; k++) begin
      if (k == 0) add(1,1,1,0, 0,0,0,"sat_lead");
      add(0,1,1,0, 0,k,0,"sat_0a"); add(0,1,1,0, 0,k,0,"sat_0b");
      add(1,1,1,0, 1,k+1,0,"sat_hit");
    end
    add(0,0,1,1, 0,0,1,"clr_sat");
    // mode switched to non-overlap just before the second hit
    add(1,1,1,0, 0,0,0,"mch_b1"); add(0,1,1,0, 0,0,0,"mch_b2");
    add(0,1,1,0, 0,0,0,"mch_b3"); add(1,1,1,0, 1,1,0,"mch_b4");
    add(0,1,0,0, 0,1,0,"mch_b5"); add(0,1,0,0, 0,1,0,"mch_b6");
    add(1,1,0,0, 1,2,1,"mch_b7");
    add(0,1,0,0, 0,2,0,"mch_b8"); add(0,1,0,0, 0,2,0,"mch_b9");
    add(1,1,0,0, 0,2,0,"mch_b10");
    add(0,0,1,1, 0,0,1,"clr3");
    // gaps of invalid cycles (I=1 ignored) do not break the sequence
    add(1,1,1,0, 0,0,0,"gap_b1"); add(0,1,1,0, 0,0,0,"gap_b2");
    add(1,0,1,0, 0,0,0,"gap_x1"); add(1,0,1,0, 0,0,0,"gap_x2");
    add(1,0,1,0, 0,0,0,"gap_x3");
    add(0,1,1,0, 0,0,0,"gap_b3"); add(1,1,1,0, 1,1,0,"gap_b4");

    // reset state
    R = 1'b1;
    #12;
    check_all("reset", 1'b0, 0);
    check("reset.state", int'(dut.state_q), int'(ST_IDLE));
    @(negedge clock); R = 1'b0;

    foreach (vecs[k]) step(vecs[k]);

    // async reset mid-cycle while F is high and count is 1
    R = 1'b1; #1;
    check_all("async_rst", 1'b0, 0);
    #1 R = 1'b0;

    // pattern straddling a reset is not detected
    bit_in(1,1,1, 0,0,"str_b1"); bit_in(0,1,1, 0,0,"str_b2");
    R = 1'b1; #1; R = 1'b0;
    bit_in(0,1,1, 0,0,"str_b3"); bit_in(1,1,1, 0,0,"str_b4");
    bit_in(1,1,1, 0,0,"str_b5");

`ifdef SEQDET_PROG_EN
    // load 0110 mid-stream; count kept, same-cycle bit dropped
    bit_in(1,1,1, 0,0,"prg_pre1"); bit_in(0,1,1, 0,0,"prg_pre2");
    bit_in(0,1,1, 0,0,"prg_pre3"); bit_in(1,1,1, 1,1,"prg_pre4");
    pat_load = 1'b1; pat_in = 4'b0110;
    bit_in(0,1,1, 0,1,"prg_load");
    pat_load = 1'b0;
    bit_in(0,1,1, 0,1,"prg_b1"); bit_in(1,1,1, 0,1,"prg_b2");
    bit_in(1,1,1, 0,1,"prg_b3"); bit_in(0,1,1, 1,2,"prg_b4");
    bit_in(1,1,1, 0,2,"prg_o1"); bit_in(0,1,1, 0,2,"prg_o2");
    bit_in(0,1,1, 0,2,"prg_o3"); bit_in(1,1,1, 0,2,"prg_o4");
`endif

    @(negedge clock); I_valid = 1'b0;
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
